// File: rtl/spu_result_pipe.sv
// Result staging pipe for the SPU issue lanes: carries issued results through DEPTH stage
// registers to write-back and answers operand-forward queries with data, hit and hazard.
module spu_result_pipe #(
   parameter int NLANES = 2,
   parameter int DEPTH  = 7,
   parameter int DW     = 128,
   parameter int AW     = 7,
   parameter int LW     = 3,
   parameter int NQ     = 3 * NLANES
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NLANES-1:0]    iss_valid,
   input  logic [NLANES*AW-1:0] iss_rt,
   input  logic [NLANES*LW-1:0] iss_lat,
   input  logic [NLANES*DW-1:0] iss_data,
   input  logic [NQ-1:0]        q_valid,
   input  logic [NQ*AW-1:0]     q_addr,
   output logic [NQ*DW-1:0]     q_data,
   output logic [NQ-1:0]        q_hit,
   output logic                 hazard,
   output logic [NLANES-1:0]    wb_valid,
   output logic [NLANES*AW-1:0] wb_rt,
   output logic [NLANES*DW-1:0] wb_data
);

   typedef struct packed {
      logic          valid;
      logic [AW-1:0] rt;
      logic [LW-1:0] lat;
      logic [DW-1:0] data;
   } entry_t;

   // Index 0 holds stage 1; index DEPTH-1 holds the write-back stage.
   entry_t stage_q [DEPTH][NLANES];

   // A zero latency still needs one stage; anything beyond the pipe is ready at the last stage.
   function automatic logic [LW-1:0] clamp_lat(input logic [LW-1:0] lat);
      if (lat == '0)
         return LW'(1);
      if (int'(lat) > DEPTH)
         return LW'(DEPTH);
      return lat;
   endfunction

   // NOTE: every stage is reset, not just the valid bits, because reset must force
   // wb_rt/wb_data and the forward outputs to zero, not merely mark entries invalid.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int s = 0; s < DEPTH; s++)
            for (int l = 0; l < NLANES; l++)
               stage_q[s][l] <= '0;
      end else begin
         // NOTE: non-blocking assignments let every stage sample its predecessor's old value.
         for (int l = 0; l < NLANES; l++) begin
            stage_q[0][l] <= '{valid: iss_valid[l],
                               rt:    iss_rt[l*AW +: AW],
                               lat:   clamp_lat(iss_lat[l*LW +: LW]),
                               data:  iss_data[l*DW +: DW]};
            for (int s = 1; s < DEPTH; s++)
               stage_q[s][l] <= stage_q[s-1][l];
         end
      end
   end

   // Youngest match wins: lowest stage first, then highest lane; an unready winner stalls.
   always_comb begin
      logic found;
      // NOTE: defaults before the loops keep every output fully assigned, so no latch forms.
      q_data = '0;
      q_hit  = '0;
      hazard = 1'b0;
      found  = 1'b0;
      for (int q = 0; q < NQ; q++) begin
         found = 1'b0;
         for (int s = 0; s < DEPTH; s++) begin
            for (int l = NLANES - 1; l >= 0; l--) begin
               if (!found && q_valid[q] && stage_q[s][l].valid &&
                   stage_q[s][l].rt == q_addr[q*AW +: AW]) begin
                  found = 1'b1;
                  if (s + 1 >= int'(stage_q[s][l].lat)) begin
                     q_hit[q]             = 1'b1;
                     q_data[q*DW +: DW] = stage_q[s][l].data;
                  end else begin
                     hazard = 1'b1;
                  end
               end
            end
         end
      end
   end

   always_comb begin
      wb_valid = '0;
      wb_rt    = '0;
      wb_data  = '0;
      for (int l = 0; l < NLANES; l++) begin
         wb_valid[l]          = stage_q[DEPTH-1][l].valid;
         wb_rt[l*AW +: AW]    = stage_q[DEPTH-1][l].rt;
         wb_data[l*DW +: DW]  = stage_q[DEPTH-1][l].data;
      end
   end

endmodule

// File: tb/tb_spu_result_pipe.sv
// Bench for spu_result_pipe: directed vector table, reset and clamp sequences, then random
// traffic against an issue-history model, on a DEPTH=7 and a DEPTH=4 instance.
module tb_spu_result_pipe;

   localparam int NL = 2;
   localparam int DW = 128;
   localparam int AW = 7;
   localparam int LW = 3;
   localparam int NQ = 3 * NL;

   logic              clk;
   logic              reset;
   logic [NL-1:0]     iss_valid;
   logic [NL*AW-1:0]  iss_rt;
   logic [NL*LW-1:0]  iss_lat;
   logic [NL*DW-1:0]  iss_data;
   logic [NQ-1:0]     q_valid;
   logic [NQ*AW-1:0]  q_addr;

   logic [NQ*DW-1:0]  q_data,   q_data4;
   logic [NQ-1:0]     q_hit,    q_hit4;
   logic              hazard,   hazard4;
   logic [NL-1:0]     wb_valid, wb_valid4;
   logic [NL*AW-1:0]  wb_rt,    wb_rt4;
   logic [NL*DW-1:0]  wb_data,  wb_data4;

   int checks = 0;
   int errors = 0;

   spu_result_pipe #(.NLANES(NL), .DEPTH(7), .DW(DW), .AW(AW), .LW(LW), .NQ(NQ)) dut (
      .clk(clk), .reset(reset),
      .iss_valid(iss_valid), .iss_rt(iss_rt), .iss_lat(iss_lat), .iss_data(iss_data),
      .q_valid(q_valid), .q_addr(q_addr),
      .q_data(q_data), .q_hit(q_hit), .hazard(hazard),
      .wb_valid(wb_valid), .wb_rt(wb_rt), .wb_data(wb_data)
   );

   spu_result_pipe #(.NLANES(NL), .DEPTH(4), .DW(DW), .AW(AW), .LW(LW), .NQ(NQ)) dut4 (
      .clk(clk), .reset(reset),
      .iss_valid(iss_valid), .iss_rt(iss_rt), .iss_lat(iss_lat), .iss_data(iss_data),
      .q_valid(q_valid), .q_addr(q_addr),
      .q_data(q_data4), .q_hit(q_hit4), .hazard(hazard4),
      .wb_valid(wb_valid4), .wb_rt(wb_rt4), .wb_data(wb_data4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Model: a list of issued results with their age in cycles since capture.
   typedef struct {
      int            lane;
      logic [AW-1:0] rt;
      int            lat;
      logic [DW-1:0] data;
      int            age;
   } rec_t;

   rec_t hist[$];

   function automatic void model_capture();
      rec_t nxt[$];
      foreach (hist[i]) begin
         rec_t r = hist[i];
         r.age++;
         if (r.age <= 7) nxt.push_back(r);
      end
      for (int l = 0; l < NL; l++)
         if (iss_valid[l])
            nxt.push_back('{l, iss_rt[l*AW +: AW], int'(iss_lat[l*LW +: LW]), iss_data[l*DW +: DW], 1});
      hist = nxt;
   endfunction

   function automatic void model_query(input int depth, input logic [AW-1:0] addr,
                                       output bit hit, output logic [DW-1:0] data, output bit haz);
      int best = -1;
      int eff;
      hit = 0; haz = 0; data = '0;
      foreach (hist[i])
         if (hist[i].age <= depth && hist[i].rt == addr)
            if (best < 0 || hist[i].age < hist[best].age ||
                (hist[i].age == hist[best].age && hist[i].lane > hist[best].lane))
               best = i;
      if (best >= 0) begin
         eff = (hist[best].lat == 0) ? 1 : (hist[best].lat > depth ? depth : hist[best].lat);
         if (hist[best].age >= eff) begin
            hit  = 1;
            data = hist[best].data;
         end else begin
            haz = 1;
         end
      end
   endfunction

   function automatic void model_wb(input int depth, input int lane, output bit v,
                                    output logic [AW-1:0] rt, output logic [DW-1:0] data);
      v = 0; rt = '0; data = '0;
      foreach (hist[i])
         if (hist[i].age == depth && hist[i].lane == lane) begin
            v = 1; rt = hist[i].rt; data = hist[i].data;
         end
   endfunction

   task automatic check_dut(input string tag, input int depth,
                            input logic [NQ*DW-1:0] qd, input logic [NQ-1:0] qh, input logic hz,
                            input logic [NL-1:0] wv, input logic [NL*AW-1:0] wr,
                            input logic [NL*DW-1:0] wd);
      bit h, z, v, any;
      logic [DW-1:0] d;
      logic [AW-1:0] r;
      any = 0;
      for (int q = 0; q < NQ; q++) begin
         h = 0; z = 0; d = '0;
         if (q_valid[q]) model_query(depth, q_addr[q*AW +: AW], h, d, z);
         any |= z;
         check($sformatf("%s q%0d hit", tag, q), DW'(qh[q]), DW'(h));
         check($sformatf("%s q%0d data", tag, q), qd[q*DW +: DW], d);
      end
      check($sformatf("%s hazard", tag), DW'(hz), DW'(any));
      for (int l = 0; l < NL; l++) begin
         model_wb(depth, l, v, r, d);
         check($sformatf("%s wb_valid%0d", tag, l), DW'(wv[l]), DW'(v));
         if (v) begin
            check($sformatf("%s wb_rt%0d", tag, l), DW'(wr[l*AW +: AW]), DW'(r));
            check($sformatf("%s wb_data%0d", tag, l), wd[l*DW +: DW], d);
         end
      end
   endtask

   task automatic check_both(input string tag);
      check_dut({tag, " d7"}, 7, q_data, q_hit, hazard, wb_valid, wb_rt, wb_data);
      check_dut({tag, " d4"}, 4, q_data4, q_hit4, hazard4, wb_valid4, wb_rt4, wb_data4);
   endtask

   task automatic step();
      model_capture();
      @(posedge clk);
      #1;
   endtask

   // Directed vectors: issue inputs applied before an edge, query 0 result expected after it.
   typedef struct {
      logic [1:0]    iv;
      logic [AW-1:0] rt0, rt1;
      logic [LW-1:0] lat0, lat1;
      logic [7:0]    d0, d1;
      logic [AW-1:0] qa;
      logic          hit;
      logic [7:0]    qd;
      logic          haz;
      logic [1:0]    wbv;
      logic [AW-1:0] wrt0, wrt1;
      logic [7:0]    wd0, wd1;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input int iv, input int rt0, input int lat0, input int d0,
                               input int rt1, input int lat1, input int d1, input int qa,
                               input int hit, input int qd, input int haz, input int wbv,
                               input int wrt0, input int wd0, input int wrt1, input int wd1);
      vec_t v;
      v.iv = 2'(iv);   v.rt0 = AW'(rt0); v.lat0 = LW'(lat0); v.d0 = 8'(d0);
      v.rt1 = AW'(rt1); v.lat1 = LW'(lat1); v.d1 = 8'(d1); v.qa = AW'(qa);
      v.hit = 1'(hit); v.qd = 8'(qd); v.haz = 1'(haz); v.wbv = 2'(wbv);
      v.wrt0 = AW'(wrt0); v.wd0 = 8'(wd0); v.wrt1 = AW'(wrt1); v.wd1 = 8'(wd1);
      return v;
   endfunction

   function automatic vec_t idle(input int qa, input int hit, input int qd, input int haz,
                                 input int wbv, input int wrt0, input int wd0,
                                 input int wrt1, input int wd1);
      return mk(0, 0, 0, 0, 0, 0, 0, qa, hit, qd, haz, wbv, wrt0, wd0, wrt1, wd1);
   endfunction

   initial begin
      // Lane0 rt=3 lat=1: forward from stage 1, write-back at stage 7.
      vecs.push_back(mk(1, 3, 1, 'hAA, 0, 0, 0, 3, 1, 'hAA, 0, 0, 0, 0, 0, 0));
      repeat (5) vecs.push_back(idle(3, 1, 'hAA, 0, 0, 0, 0, 0, 0));
      vecs.push_back(idle(3, 1, 'hAA, 0, 1, 3, 'hAA, 0, 0));
      vecs.push_back(idle(3, 0, 0, 0, 0, 0, 0, 0, 0));
      // Lane1 rt=5 lat=4: hazard at stages 1-3, forward from stage 4.
      vecs.push_back(mk(2, 0, 0, 0, 5, 4, 'h55, 5, 0, 0, 1, 0, 0, 0, 0, 0));
      repeat (2) vecs.push_back(idle(5, 0, 0, 1, 0, 0, 0, 0, 0));
      repeat (3) vecs.push_back(idle(5, 1, 'h55, 0, 0, 0, 0, 0, 0));
      vecs.push_back(idle(5, 1, 'h55, 0, 2, 0, 0, 5, 'h55));
      vecs.push_back(idle(5, 0, 0, 0, 0, 0, 0, 0, 0));
      // Younger unready rt=9 blocks the older ready rt=9.
      vecs.push_back(mk(1, 9, 1, 'h11, 0, 0, 0, 9, 1, 'h11, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 9, 6, 'h22, 0, 0, 0, 9, 0, 0, 1, 0, 0, 0, 0, 0));
      repeat (4) vecs.push_back(idle(9, 0, 0, 1, 0, 0, 0, 0, 0));
      vecs.push_back(idle(9, 1, 'h22, 0, 1, 9, 'h11, 0, 0));
      vecs.push_back(idle(9, 1, 'h22, 0, 1, 9, 'h22, 0, 0));
      vecs.push_back(idle(9, 0, 0, 0, 0, 0, 0, 0, 0));
      // Both lanes rt=4 in one cycle: lane1 forwards, both write back.
      vecs.push_back(mk(3, 4, 1, 'h01, 4, 1, 'h02, 4, 1, 'h02, 0, 0, 0, 0, 0, 0));
      repeat (5) vecs.push_back(idle(4, 1, 'h02, 0, 0, 0, 0, 0, 0));
      vecs.push_back(idle(4, 1, 'h02, 0, 3, 4, 'h01, 4, 'h02));
      vecs.push_back(idle(4, 0, 0, 0, 0, 0, 0, 0, 0));
      // Latency 0 behaves as latency 1.
      vecs.push_back(mk(1, 6, 0, 'h66, 0, 0, 0, 6, 1, 'h66, 0, 0, 0, 0, 0, 0));
      repeat (5) vecs.push_back(idle(6, 1, 'h66, 0, 0, 0, 0, 0, 0));
      vecs.push_back(idle(6, 1, 'h66, 0, 1, 6, 'h66, 0, 0));
      vecs.push_back(idle(6, 0, 0, 0, 0, 0, 0, 0, 0));

      reset = 1'b0;
      iss_valid = '0; iss_rt = '0; iss_lat = '0; iss_data = '0;
      q_valid = '1; q_addr = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset wb_valid", DW'(wb_valid), '0);
      check("reset wb_rt", DW'(wb_rt), '0);
      check("reset wb_data", wb_data[DW-1:0], '0);
      check("reset q_hit", DW'(q_hit), '0);
      check("reset hazard", DW'(hazard), '0);
      reset = 1'b1;
      hist.delete();

      foreach (vecs[i]) begin
         iss_valid = vecs[i].iv;
         iss_rt    = {vecs[i].rt1, vecs[i].rt0};
         iss_lat   = {vecs[i].lat1, vecs[i].lat0};
         iss_data  = '0;
         iss_data[7:0]     = vecs[i].d0;
         iss_data[DW +: 8] = vecs[i].d1;
         q_valid = NQ'(1);
         q_addr  = '0;
         q_addr[AW-1:0] = vecs[i].qa;
         step();
         check($sformatf("row%0d hit", i), DW'(q_hit[0]), DW'(vecs[i].hit));
         check($sformatf("row%0d data", i), q_data[DW-1:0], DW'(vecs[i].qd));
         check($sformatf("row%0d hazard", i), DW'(hazard), DW'(vecs[i].haz));
         check($sformatf("row%0d wb_valid", i), DW'(wb_valid), DW'(vecs[i].wbv));
         if (vecs[i].wbv[0]) begin
            check($sformatf("row%0d wb_rt0", i), DW'(wb_rt[AW-1:0]), DW'(vecs[i].wrt0));
            check($sformatf("row%0d wb_data0", i), wb_data[DW-1:0], DW'(vecs[i].wd0));
         end
         if (vecs[i].wbv[1]) begin
            check($sformatf("row%0d wb_rt1", i), DW'(wb_rt[AW +: AW]), DW'(vecs[i].wrt1));
            check($sformatf("row%0d wb_data1", i), wb_data[DW +: DW], DW'(vecs[i].wd1));
         end
      end

      // Five results in flight, then an asynchronous reset between edges.
      q_valid = NQ'(1);
      q_addr  = '0;
      q_addr[AW-1:0] = AW'(10);
      iss_lat = {LW'(1), LW'(1)};
      for (int i = 0; i < 5; i++) begin
         iss_valid = 2'b01;
         iss_rt    = {AW'(0), AW'(10 + i)};
         iss_data  = {DW'(0), DW'(32'h100 + i)};
         step();
         check_both($sformatf("inflight%0d", i));
      end
      iss_valid = '0;
      #2;
      reset = 1'b0;
      #1;
      hist.delete();
      check("midreset wb_valid", DW'(wb_valid), '0);
      check("midreset wb_valid d4", DW'(wb_valid4), '0);
      check_both("midreset");
      @(posedge clk);
      #1;
      reset = 1'b1;
      for (int i = 0; i < 8; i++) begin
         q_addr[AW-1:0] = AW'(10 + (i % 5));
         step();
         check($sformatf("postreset%0d wb_valid", i), DW'(wb_valid), '0);
         check_both($sformatf("postreset%0d", i));
      end

      // Latency 7 on the DEPTH=4 instance clamps to 4.
      iss_valid = 2'b01;
      iss_rt    = {AW'(0), AW'(8)};
      iss_lat   = {LW'(0), LW'(7)};
      iss_data  = {DW'(0), DW'('h77)};
      q_addr[AW-1:0] = AW'(8);
      for (int k = 1; k <= 4; k++) begin
         step();
         iss_valid = '0;
         check($sformatf("clamp%0d d4 hazard", k), DW'(hazard4), DW'(k < 4));
         check($sformatf("clamp%0d d4 hit", k), DW'(q_hit4[0]), DW'(k == 4));
         check($sformatf("clamp%0d d4 data", k), q_data4[DW-1:0], (k == 4) ? DW'('h77) : '0);
         check($sformatf("clamp%0d d4 wb_valid", k), DW'(wb_valid4[0]), DW'(k == 4));
         check($sformatf("clamp%0d d7 hazard", k), DW'(hazard), DW'(1));
         check_both($sformatf("clamp%0d", k));
      end
      repeat (4) begin
         step();
         check_both("drain");
      end

      // Random traffic on a small register range to force collisions and hazards.
      for (int c = 0; c < 500; c++) begin
         iss_valid = NL'($urandom_range(0, 3));
         for (int l = 0; l < NL; l++) begin
            iss_rt[l*AW +: AW]   = AW'($urandom_range(0, 7));
            iss_lat[l*LW +: LW]  = LW'($urandom_range(0, 7));
            iss_data[l*DW +: DW] = {$urandom(), $urandom(), $urandom(), $urandom()};
         end
         q_valid = NQ'($urandom());
         for (int q = 0; q < NQ; q++)
            q_addr[q*AW +: AW] = AW'($urandom_range(0, 7));
         step();
         check_both($sformatf("rand%0d", c));
         if ($urandom_range(0, 49) == 0) begin
            reset = 1'b0;
            #1;
            hist.delete();
            check_both($sformatf("rand%0d reset", c));
            @(posedge clk);
            #1;
            reset = 1'b1;
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
